// File: rtl/bsw_pkg.sv
// Shared FSM encoding and length-to-word helper for the banded Smith-Waterman tile loader.
// A "word" here is one BRAM entry holding 2**block_width bases.
package bsw_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ARRAY,
    ST_LOAD_REF,
    ST_LOAD_QUERY,
    ST_FLUSH,
    ST_START
  } state_t;

  // Number of words needed to hold len bases, rounding a partial word up.
  function automatic logic [31:0] words_for_len(input logic [31:0] len,
                                                input int unsigned block_width);
    logic [31:0] round_up;
    round_up = (32'd1 << block_width) - 32'd1;
    return (len + round_up) >> block_width;
  endfunction

endpackage

// File: rtl/bsw_tile_loader.sv
// Loads one tile (ref then query words) into the array BRAMs and pulses start; writes land 1 cycle
// after each accepted beat, start 2 cycles after the last beat; seq_valid gaps simply stall the load.
module bsw_tile_loader
  import bsw_pkg::*;
#(
  parameter int LOG_MAX_TILE_SIZE = 11,
  parameter int BLOCK_WIDTH = 3,
  localparam int AW = LOG_MAX_TILE_SIZE - BLOCK_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          desc_valid,
  output logic                          desc_ready,
  input  logic [LOG_MAX_TILE_SIZE-1:0]  desc_ref_len,
  input  logic [LOG_MAX_TILE_SIZE-1:0]  desc_query_len,
  input  logic [7:0]                    desc_align_fields,
  input  logic [31:0]                   desc_tile_id,
  input  logic                          seq_valid,
  output logic                          seq_ready,
  input  logic [8*(2**BLOCK_WIDTH)-1:0] seq_data,
  input  logic                          array_ready,
  output logic                          ref_wr_en,
  output logic                          query_wr_en,
  output logic [AW-1:0]                 ref_addr,
  output logic [AW-1:0]                 query_addr,
  output logic [8*(2**BLOCK_WIDTH)-1:0] ref_in,
  output logic [8*(2**BLOCK_WIDTH)-1:0] query_in,
  output logic [LOG_MAX_TILE_SIZE-1:0]  ref_len,
  output logic [LOG_MAX_TILE_SIZE-1:0]  query_len,
  output logic [7:0]                    align_fields,
  output logic [31:0]                   tile_id,
  output logic                          start,
  output logic                          busy
);

  localparam int AWP1 = AW + 1;

  state_t          state, state_nxt;
  logic [AW:0]     ref_words, query_words, phase_words, beat_cnt;
  logic            last_beat;

  assign ref_words   = AWP1'(words_for_len(32'(ref_len), BLOCK_WIDTH));
  assign query_words = AWP1'(words_for_len(32'(query_len), BLOCK_WIDTH));
  assign phase_words = (state == ST_LOAD_REF) ? ref_words : query_words;
  assign last_beat   = (beat_cnt + AWP1'(1)) == phase_words;

  assign start = (state == ST_START);
  assign busy  = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    desc_ready = 1'b0;
    seq_ready  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        desc_ready = 1'b1;
        if (desc_valid) state_nxt = ST_WAIT_ARRAY;
      end
      ST_WAIT_ARRAY: begin
        // Empty sequences skip their load phase entirely.
        if (array_ready) begin
          if (ref_words != '0)        state_nxt = ST_LOAD_REF;
          else if (query_words != '0) state_nxt = ST_LOAD_QUERY;
          else                        state_nxt = ST_START;
        end
      end
      ST_LOAD_REF: begin
        seq_ready = 1'b1;
        if (seq_valid && last_beat)
          state_nxt = (query_words == '0) ? ST_FLUSH : ST_LOAD_QUERY;
      end
      ST_LOAD_QUERY: begin
        seq_ready = 1'b1;
        if (seq_valid && last_beat) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: state_nxt = ST_START;
      ST_START: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_wr_en    <= 1'b0;
      query_wr_en  <= 1'b0;
      ref_addr     <= '0;
      query_addr   <= '0;
      ref_in       <= '0;
      query_in     <= '0;
      ref_len      <= '0;
      query_len    <= '0;
      align_fields <= '0;
      tile_id      <= '0;
      beat_cnt     <= '0;
    end else begin
      ref_wr_en   <= 1'b0;
      query_wr_en <= 1'b0;
      if (desc_valid && desc_ready) begin
        ref_len      <= desc_ref_len;
        query_len    <= desc_query_len;
        align_fields <= desc_align_fields;
        tile_id      <= desc_tile_id;
        beat_cnt     <= '0;
      end
      // Word addresses are 1-based and wrap, so beat 2**AW-1 lands on address 0.
      if (seq_valid && seq_ready) begin
        if (state == ST_LOAD_REF) begin
          ref_wr_en <= 1'b1;
          ref_addr  <= beat_cnt[AW-1:0] + AW'(1);
          ref_in    <= seq_data;
        end else begin
          query_wr_en <= 1'b1;
          query_addr  <= beat_cnt[AW-1:0] + AW'(1);
          query_in    <= seq_data;
        end
        beat_cnt <= last_beat ? '0 : beat_cnt + AWP1'(1);
      end
    end
  end

endmodule

// File: tb/tb_bsw_tile_loader.sv
// Directed bench for bsw_tile_loader: a negedge monitor logs writes and start pulses,
// one initial block drives tiles and checks logs against hand-computed values.
module tb_bsw_tile_loader;

  localparam int LMT = 11;
  localparam int BW  = 3;
  localparam int AW  = 8;
  localparam int DW  = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           desc_valid = 1'b0;
  logic           desc_ready;
  logic [LMT-1:0] desc_ref_len = '0;
  logic [LMT-1:0] desc_query_len = '0;
  logic [7:0]     desc_align_fields = '0;
  logic [31:0]    desc_tile_id = '0;
  logic           seq_valid = 1'b0;
  logic           seq_ready;
  logic [DW-1:0]  seq_data = '0;
  logic           array_ready = 1'b1;
  logic           ref_wr_en, query_wr_en;
  logic [AW-1:0]  ref_addr, query_addr;
  logic [DW-1:0]  ref_in, query_in;
  logic [LMT-1:0] ref_len, query_len;
  logic [7:0]     align_fields;
  logic [31:0]    tile_id;
  logic           start, busy;

  bsw_tile_loader #(.LOG_MAX_TILE_SIZE(LMT), .BLOCK_WIDTH(BW)) dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_ref_len(desc_ref_len), .desc_query_len(desc_query_len),
    .desc_align_fields(desc_align_fields), .desc_tile_id(desc_tile_id),
    .seq_valid(seq_valid), .seq_ready(seq_ready), .seq_data(seq_data),
    .array_ready(array_ready),
    .ref_wr_en(ref_wr_en), .query_wr_en(query_wr_en),
    .ref_addr(ref_addr), .query_addr(query_addr),
    .ref_in(ref_in), .query_in(query_in),
    .ref_len(ref_len), .query_len(query_len),
    .align_fields(align_fields), .tile_id(tile_id),
    .start(start), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int ref_addr_q[$];
  int query_addr_q[$];
  logic [DW-1:0] ref_dat_q[$];
  logic [DW-1:0] query_dat_q[$];
  int start_cnt, both_cnt, hs_cnt, start_cyc, last_beat_cyc;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ref_wr_en) begin
      ref_addr_q.push_back(int'(ref_addr));
      ref_dat_q.push_back(ref_in);
    end
    if (query_wr_en) begin
      query_addr_q.push_back(int'(query_addr));
      query_dat_q.push_back(query_in);
    end
    if (ref_wr_en && query_wr_en) both_cnt++;
    if (start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (seq_valid && seq_ready) begin
      hs_cnt++;
      last_beat_cyc = cyc;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] bd(input int k);
    return {32'(32'hD00D0000 + k), 32'(32'h12340000 + k * 7)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    ref_addr_q.delete();
    query_addr_q.delete();
    ref_dat_q.delete();
    query_dat_q.delete();
    start_cnt = 0;
    both_cnt = 0;
    hs_cnt = 0;
    start_cyc = 0;
    last_beat_cyc = 0;
  endtask

  task automatic send_desc(input int rl, input int ql, input logic [7:0] af, input logic [31:0] id);
    desc_ref_len = LMT'(rl);
    desc_query_len = LMT'(ql);
    desc_align_fields = af;
    desc_tile_id = id;
    desc_valid = 1'b1;
    @(negedge clk);
    chk("desc_ready_idle", {63'd0, desc_ready}, 64'd1);
    @(posedge clk); #1;
    desc_valid = 1'b0;
  endtask

  task automatic feed(input int n, input bit gap, input int base);
    int sent = 0;
    int guard = 0;
    bit hs;
    while (sent < n && guard < 2000) begin
      seq_valid = gap ? (guard % 2 == 0) : 1'b1;
      seq_data = bd(base + sent);
      @(negedge clk);
      hs = seq_valid && seq_ready;
      @(posedge clk); #1;
      if (hs) sent++;
      guard++;
    end
    seq_valid = 1'b0;
    chk("feed_beats", 64'(sent), 64'(n));
  endtask

  task automatic wait_idle(input int budget);
    int g = 0;
    @(negedge clk);
    while (busy && g < budget) begin
      @(negedge clk);
      g++;
    end
    chk("idle_timeout", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int rdy_seen;
    clear_logs();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_desc_ready", {63'd0, desc_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_seq_ready", {63'd0, seq_ready}, 64'd0);
    chk("rst_strobes", {62'd0, ref_wr_en, query_wr_en}, 64'd0);
    chk("rst_start", {63'd0, start}, 64'd0);
    chk("rst_held", {ref_len, query_len, align_fields, tile_id}, 64'd0);
    chk("rst_addr", {ref_addr, query_addr}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic tile: 2 ref words, 2 query words, back-to-back beats
    clear_logs();
    send_desc(16, 9, 8'h5A, 32'hCAFE0001);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    chk("t1_desc_ready", {63'd0, desc_ready}, 64'd0);
    chk("t1_held", {ref_len, query_len, align_fields, tile_id},
        {11'd16, 11'd9, 8'h5A, 32'hCAFE0001});
    feed(4, 1'b0, 0);
    wait_idle(20);
    chk("t1_ref_n", 64'(ref_addr_q.size()), 64'd2);
    chk("t1_ref_a0", 64'(ref_addr_q[0]), 64'd1);
    chk("t1_ref_a1", 64'(ref_addr_q[1]), 64'd2);
    chk("t1_ref_d1", ref_dat_q[1], bd(1));
    chk("t1_qry_n", 64'(query_addr_q.size()), 64'd2);
    chk("t1_qry_a0", 64'(query_addr_q[0]), 64'd1);
    chk("t1_qry_a1", 64'(query_addr_q[1]), 64'd2);
    chk("t1_qry_d0", query_dat_q[0], bd(2));
    chk("t1_qry_d1", query_dat_q[1], bd(3));
    chk("t1_start_n", 64'(start_cnt), 64'd1);
    chk("t1_start_lat", 64'(start_cyc - last_beat_cyc), 64'd2);
    chk("t1_overlap", 64'(both_cnt), 64'd0);
    chk("t1_held_after", {ref_len, tile_id}, {53'd16, 32'hCAFE0001} & 64'h7FF_FFFFFFFF);
    chk("t1_desc_ready_end", {63'd0, desc_ready}, 64'd1);

    // Empty tile
    clear_logs();
    send_desc(0, 0, 8'h00, 32'h00000002);
    wait_idle(10);
    chk("t2_writes", 64'(ref_addr_q.size() + query_addr_q.size()), 64'd0);
    chk("t2_start_n", 64'(start_cnt), 64'd1);
    chk("t2_desc_ready", {63'd0, desc_ready}, 64'd1);

    // Array not ready for 10 cycles; a second descriptor is offered meanwhile
    clear_logs();
    array_ready = 1'b0;
    send_desc(8, 8, 8'h3C, 32'h00000003);
    seq_valid = 1'b1;
    desc_valid = 1'b1;
    desc_ref_len = 11'd100;
    desc_tile_id = 32'hDEADBEEF;
    rdy_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (seq_ready) rdy_seen++;
      @(posedge clk); #1;
    end
    desc_valid = 1'b0;
    seq_valid = 1'b0;
    chk("t3_seq_ready_cycles", 64'(rdy_seen), 64'd0);
    chk("t3_no_writes", 64'(ref_addr_q.size() + query_addr_q.size()), 64'd0);
    chk("t3_held_kept", {ref_len, tile_id}, {21'd0, 11'd8, 32'h00000003});
    array_ready = 1'b1;
    feed(2, 1'b0, 50);
    wait_idle(20);
    chk("t3_ref_a0", 64'(ref_addr_q[0]), 64'd1);
    chk("t3_ref_d0", ref_dat_q[0], bd(50));
    chk("t3_qry_a0", 64'(query_addr_q[0]), 64'd1);
    chk("t3_start_n", 64'(start_cnt), 64'd1);

    // Maximum ref length: 256 words, address wraps to 0 on the last one
    clear_logs();
    send_desc(2047, 8, 8'h01, 32'h00000004);
    feed(257, 1'b0, 1000);
    wait_idle(20);
    chk("t4_ref_n", 64'(ref_addr_q.size()), 64'd256);
    chk("t4_ref_first", 64'(ref_addr_q[0]), 64'd1);
    chk("t4_ref_255", 64'(ref_addr_q[254]), 64'd255);
    chk("t4_ref_last", 64'(ref_addr_q[255]), 64'd0);
    chk("t4_ref_last_d", ref_dat_q[255], bd(1255));
    chk("t4_qry_a0", 64'(query_addr_q[0]), 64'd1);
    chk("t4_qry_d0", query_dat_q[0], bd(1256));
    chk("t4_overlap", 64'(both_cnt), 64'd0);

    // seq_valid toggling, no query words
    clear_logs();
    send_desc(24, 0, 8'h02, 32'h00000005);
    feed(3, 1'b1, 200);
    wait_idle(20);
    chk("t5_ref_n", 64'(ref_addr_q.size()), 64'd3);
    chk("t5_ref_a0", 64'(ref_addr_q[0]), 64'd1);
    chk("t5_ref_a1", 64'(ref_addr_q[1]), 64'd2);
    chk("t5_ref_a2", 64'(ref_addr_q[2]), 64'd3);
    chk("t5_ref_d2", ref_dat_q[2], bd(202));
    chk("t5_qry_n", 64'(query_addr_q.size()), 64'd0);
    chk("t5_start_n", 64'(start_cnt), 64'd1);

    // Reset in the middle of a 5-word ref load
    clear_logs();
    send_desc(40, 8, 8'h03, 32'h00000006);
    feed(3, 1'b0, 300);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_busy", {63'd0, busy}, 64'd0);
    chk("t6_strobes", {62'd0, ref_wr_en, query_wr_en}, 64'd0);
    chk("t6_seq_ready", {63'd0, seq_ready}, 64'd0);
    chk("t6_desc_ready", {63'd0, desc_ready}, 64'd1);
    chk("t6_held", {ref_len, query_len, tile_id}, 64'd0);
    chk("t6_addr", {ref_addr, query_addr}, 64'd0);
    rst = 1'b0;
    seq_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    seq_valid = 1'b0;
    chk("t6_ref_n", 64'(ref_addr_q.size()), 64'd3);
    chk("t6_ref_a2", 64'(ref_addr_q[2]), 64'd3);
    chk("t6_qry_n", 64'(query_addr_q.size()), 64'd0);
    chk("t6_no_start", 64'(start_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
